l1a_lct_matcher: RTL

//  Trigger-control core that matches CMS L1 accepts against the LCT pattern received from the TMB.

---
 rtl/l1a_lct_matcher_pkg.sv | 26 ++
 rtl/l1a_lct_matcher_if.sv | 24 ++
 rtl/l1a_lct_matcher_delay.sv | 41 ++++
 rtl/l1a_lct_matcher.sv | 117 +++++++++++
 4 files changed

// File: rtl/l1a_lct_matcher_pkg.sv
// Shared definitions for the L1A/LCT matcher: FSM encoding, defaults,
// the voted control bundle and small helpers.
package l1a_lct_matcher_pkg;

    localparam int WIN_DEF    = 3;
    localparam int MAXLAT_DEF = 64;
    localparam int CNT_W      = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

    typedef struct packed {
        logic [0:0]       state;
        logic [2:0]       wcnt;
        logic [CNT_W-1:0] miss;
    } ctl_t;

    function automatic ctl_t vote3(input ctl_t a, input ctl_t b, input ctl_t c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/l1a_lct_matcher_if.sv
// Trigger-side bundle: L1A/LCT/latency in, match/push/error/miss out.
interface l1a_lct_matcher_if;
    import l1a_lct_matcher_pkg::*;

    logic             l1a;
    logic [5:0]       lct;
    logic [5:0]       l1latncy;
    logic [4:0]       l1a_match;
    logic             l1acfeb;
    logic             gfpush;
    logic             lcterr;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output l1a, lct, l1latncy,
        input  l1a_match, l1acfeb, gfpush, lcterr, miss_cnt
    );

    modport slave (
        input  l1a, lct, l1latncy,
        output l1a_match, l1acfeb, gfpush, lcterr, miss_cnt
    );

endinterface

// File: rtl/l1a_lct_matcher_delay.sv
// SRL-style LCT delay line with a registered tap select (0 behaves as 1).
module lct_delay_line
    import l1a_lct_matcher_pkg::*;
#(
    parameter int MAXLAT = MAXLAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] din,
    input  logic [5:0] sel,
    output logic [5:0] dout
);

    logic [5:0] sr [MAXLAT];
    logic [5:0] sel_q;
    logic [5:0] tap;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAXLAT; i++)
                sr[i] <= '0;
            sel_q <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < MAXLAT; i++)
                sr[i] <= sr[i-1];
            sel_q <= sel;
        end
    end

    // sr[0] already holds the input register stage, so a tap of N reads sr[N-1]
    assign tap = (sel_q == 6'd0) ? 6'd1 : sel_q;

    always_comb begin
        dout = '0;
        for (int i = 0; i < MAXLAT; i++)
            if (tap == 6'(i + 1))
                dout = sr[i];
    end

endmodule

// File: rtl/l1a_lct_matcher.sv
// Matches L1 accepts against delayed LCTs inside a short window and
// drives per-CFEB match, CFEB L1A, global FIFO push and error/miss status.
module l1a_lct_matcher
    import l1a_lct_matcher_pkg::*;
#(
    parameter int TMR    = 0,
    parameter int WIN    = WIN_DEF,
    parameter int MAXLAT = MAXLAT_DEF
) (
    input logic              clk,
    input logic              rst,
    l1a_lct_matcher_if.slave bus
);

    localparam logic [2:0] WLOAD    = 3'(WIN - 1);
    localparam bit         ONE_SHOT = (WIN == 1);

    logic [5:0] dlct;
    ctl_t       ctl_v;
    ctl_t       ctl_n;
    logic [4:0] mask_q;
    logic [4:0] mask_n;
    logic [4:0] matched;

    logic [4:0] match_q;
    logic       cfeb_q;
    logic       gfpush_q;
    logic       lcterr_q;

    lct_delay_line #(
        .MAXLAT (MAXLAT)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.lct),
        .sel  (bus.l1latncy),
        .dout (dlct)
    );

    always_comb begin
        ctl_n   = ctl_v;
        mask_n  = mask_q;
        matched = '0;
        case (ctl_v.state)
            ST_IDLE: begin
                if (dlct[0]) begin
                    if (bus.l1a) begin
                        matched = dlct[5:1];
                    end else if (ONE_SHOT) begin
                        ctl_n.miss = sat_inc(ctl_v.miss);
                    end else begin
                        ctl_n.state = ST_OPEN;
                        ctl_n.wcnt  = WLOAD;
                        mask_n      = dlct[5:1];
                    end
                end
            end
            ST_OPEN: begin
                if (bus.l1a) begin
                    matched     = mask_q | (dlct[0] ? dlct[5:1] : 5'd0);
                    ctl_n.state = ST_IDLE;
                end else if (dlct[0]) begin
                    mask_n     = mask_q | dlct[5:1];
                    ctl_n.wcnt = WLOAD;
                end else if (ctl_v.wcnt == 3'd0) begin
                    ctl_n.state = ST_IDLE;
                    ctl_n.miss  = sat_inc(ctl_v.miss);
                end else begin
                    ctl_n.wcnt = ctl_v.wcnt - 3'd1;
                end
            end
        endcase
    end

    // Control state is replicated and voted; each copy reloads from the vote
    if (TMR != 0) begin : g_tmr
        ctl_t ctl_r [3];

        always_ff @(posedge clk) begin
            for (int i = 0; i < 3; i++)
                ctl_r[i] <= rst ? '0 : ctl_n;
        end

        assign ctl_v = vote3(ctl_r[0], ctl_r[1], ctl_r[2]);
    end else begin : g_one
        ctl_t ctl_r;

        always_ff @(posedge clk) begin
            ctl_r <= rst ? '0 : ctl_n;
        end

        assign ctl_v = ctl_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= '0;
            match_q  <= '0;
            cfeb_q   <= 1'b0;
            gfpush_q <= 1'b0;
            lcterr_q <= 1'b0;
        end else begin
            mask_q   <= mask_n;
            match_q  <= matched;
            cfeb_q   <= |matched;
            gfpush_q <= bus.l1a;
            lcterr_q <= ~dlct[0] & (|dlct[5:1]);
        end
    end

    assign bus.l1a_match = match_q;
    assign bus.l1acfeb   = cfeb_q;
    assign bus.gfpush    = gfpush_q;
    assign bus.lcterr    = lcterr_q;
    assign bus.miss_cnt  = ctl_v.miss;

endmodule
